// File: rtl/rpsc_pkg.sv
// Shared types and helpers for the RPSC fault annunciator.
package rpsc_pkg;
    localparam int unsigned RPSC_N_CH  = 8;
    localparam int unsigned RPSC_IDX_W = $clog2(RPSC_N_CH);

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic [1:0] {A_IDLE, A_PULSE, A_SETTLE, A_CHECK} ack_state_t;

    // Lowest set bit index; 0 when nothing is set.
    function automatic logic [RPSC_IDX_W-1:0] lowest_set_idx(input logic [RPSC_N_CH-1:0] v);
        logic [RPSC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(RPSC_N_CH) - 1; i >= 0; i--) begin
            if (v[i]) idx = RPSC_IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/rpsc_serial_tx.sv
// Parallel-load UART-style shifter: bit 0 of the frame goes out first, each bit held BIT_DIV cycles.
module rpsc_serial_tx #(
    parameter int unsigned FRAME_W = 15,
    parameter int unsigned BIT_DIV = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_ser_tx,
    output logic               o_busy,
    output logic               o_last_c
);
    localparam int unsigned DIV_W = $clog2(BIT_DIV);
    localparam int unsigned BIT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] r_shift;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic               r_busy;
    logic               w_bit_end;

    assign w_bit_end = (r_div == DIV_W'(BIT_DIV - 1));
    assign o_last_c  = r_busy && w_bit_end && (r_bit == BIT_W'(FRAME_W - 1));
    assign o_ser_tx  = r_shift[0];
    assign o_busy    = r_busy;

    // Ones are shifted in behind the frame so the line rests high once the stop bit leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '1;
            r_div   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_shift <= i_frame;
            r_div   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_div   <= '0;
                r_shift <= {1'b1, r_shift[FRAME_W-1:1]};
                if (r_bit == BIT_W'(FRAME_W - 1)) begin
                    r_busy <= 1'b0;
                    r_bit  <= '0;
                end else begin
                    r_bit <= r_bit + BIT_W'(1);
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/rpsc_fault_annunciator.sv
// Latched-alarm annunciator: LA sync, first-out capture, serial status frames and
// acknowledge-driven channel reset pulses with stuck-channel detection.
module rpsc_fault_annunciator
    import rpsc_pkg::*;
#(
    parameter int unsigned N_CH      = RPSC_N_CH,
    parameter int unsigned IDX_W     = $clog2(N_CH),
    parameter int unsigned RST_PULSE = 16,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned BIT_DIV   = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  la_in,
    input  logic             ack_req,
    input  logic [N_CH-1:0]  ack_mask,
    output logic [N_CH-1:0]  ch_reset,
    output logic             any_alarm,
    output logic             first_valid,
    output logic [IDX_W-1:0] first_idx,
    output logic [N_CH-1:0]  stuck,
    output logic             ser_tx,
    output logic             tx_busy
);
    localparam int unsigned FRAME_W = N_CH + IDX_W + 4;
    localparam int unsigned CNT_MAX = (RST_PULSE > SETTLE + 2) ? RST_PULSE : SETTLE + 2;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [N_CH-1:0]    r_la_m, r_la_s, r_la_d;
    logic               w_change;
    logic               r_any;
    logic               r_fv, w_fv_nxt, w_fv_clr;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;

    tx_state_t          r_tx_state, w_tx_state_nxt;
    logic               r_pending, w_pending_nxt;
    logic               w_tx_start, w_tx_last;
    logic [FRAME_W-1:0] w_frame;

    ack_state_t         r_ack_state, w_ack_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [N_CH-1:0]    r_sel, w_sel_nxt, w_sel_cap;
    logic [N_CH-1:0]    r_ch_reset, w_ch_reset_nxt;
    logic [N_CH-1:0]    r_stuck, w_stuck_nxt;

    assign w_change    = (r_la_s != r_la_d);
    assign w_sel_cap   = ack_mask & r_la_s;
    assign ch_reset    = r_ch_reset;
    assign any_alarm   = r_any;
    assign first_valid = r_fv;
    assign first_idx   = r_idx;
    assign stuck       = r_stuck;

    // First-out capture wins over clearing; clearing needs la_s==0 so the two never collide.
    always_comb begin
        w_fv_nxt  = r_fv;
        w_idx_nxt = r_idx;
        if (!r_fv && (r_la_s != '0)) begin
            w_fv_nxt  = 1'b1;
            w_idx_nxt = IDX_W'(lowest_set_idx(RPSC_N_CH'(r_la_s)));
        end else if (w_fv_clr) begin
            w_fv_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_la_m <= '0;
            r_la_s <= '0;
            r_la_d <= '0;
            r_any  <= 1'b0;
            r_fv   <= 1'b0;
            r_idx  <= '0;
        end else begin
            r_la_m <= la_in;
            r_la_s <= r_la_m;
            r_la_d <= r_la_s;
            r_any  <= |r_la_s;
            r_fv   <= w_fv_nxt;
            r_idx  <= w_idx_nxt;
        end
    end

    // Transmitter FSM: state register, next state, outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_pending  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_pending  <= w_pending_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_change) w_tx_state_nxt = TX_SHIFT;
            TX_SHIFT: if (w_tx_last && !r_pending && !w_change) w_tx_state_nxt = TX_IDLE;
            default:  w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_start    = 1'b0;
        w_pending_nxt = 1'b0;
        case (r_tx_state)
            TX_IDLE:  w_tx_start = w_change;
            TX_SHIFT: begin
                w_tx_start    = w_tx_last && (r_pending || w_change);
                w_pending_nxt = !w_tx_start && (r_pending || w_change);
            end
            default: ;
        endcase
    end

    // Snapshot carries the first-out values as they will be after this edge.
    assign w_frame = {1'b1, ^{r_la_s, w_idx_nxt, w_fv_nxt}, w_fv_nxt, w_idx_nxt, r_la_s, 1'b0};

    rpsc_serial_tx #(
        .FRAME_W (FRAME_W),
        .BIT_DIV (BIT_DIV)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_tx_start),
        .i_frame  (w_frame),
        .o_ser_tx (ser_tx),
        .o_busy   (tx_busy),
        .o_last_c (w_tx_last)
    );

    // Acknowledge FSM: state register, next state, outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_state <= A_IDLE;
        end else begin
            r_ack_state <= w_ack_state_nxt;
        end
    end

    always_comb begin
        w_ack_state_nxt = r_ack_state;
        case (r_ack_state)
            A_IDLE:   if (ack_req && (w_sel_cap != '0)) w_ack_state_nxt = A_PULSE;
            A_PULSE:  if (r_cnt == CNT_W'(RST_PULSE - 1)) w_ack_state_nxt = A_SETTLE;
            A_SETTLE: if (r_cnt == CNT_W'(SETTLE + 1)) w_ack_state_nxt = A_CHECK;
            A_CHECK:  w_ack_state_nxt = A_IDLE;
            default:  w_ack_state_nxt = A_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = '0;
        w_sel_nxt      = r_sel;
        w_stuck_nxt    = r_stuck;
        w_fv_clr       = 1'b0;
        if ((w_ack_state_nxt == r_ack_state) && (r_ack_state != A_IDLE)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if ((r_ack_state == A_IDLE) && ack_req) begin
            w_sel_nxt = w_sel_cap;
            w_fv_clr  = (r_la_s == '0);
        end
        if (r_ack_state == A_CHECK) begin
            w_stuck_nxt = r_stuck | (r_sel & r_la_s);
            w_fv_clr    = (r_la_s == '0);
        end
        w_ch_reset_nxt = (w_ack_state_nxt == A_PULSE) ? w_sel_nxt : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_sel      <= '0;
            r_ch_reset <= '0;
            r_stuck    <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_ch_reset <= w_ch_reset_nxt;
            r_stuck    <= w_stuck_nxt;
        end
    end
endmodule

// File: tb/tb_rpsc_fault_annunciator.sv
// Randomised bench for rpsc_fault_annunciator with a queue/timer-based reference model
// and a card model that clears its latches on ch_reset.
module tb_rpsc_fault_annunciator;
    localparam int RP = 16;
    localparam int ST = 4;
    localparam int BD = 4;
    localparam int FW = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] la_in, ack_mask, ch_reset, stuck;
    logic       ack_req, any_alarm, first_valid, ser_tx, tx_busy;
    logic [2:0] first_idx;

    rpsc_fault_annunciator #(.RST_PULSE(RP), .SETTLE(ST), .BIT_DIV(BD)) dut (
        .clk(clk), .reset(reset), .la_in(la_in), .ack_req(ack_req), .ack_mask(ack_mask),
        .ch_reset(ch_reset), .any_alarm(any_alarm), .first_valid(first_valid),
        .first_idx(first_idx), .stuck(stuck), .ser_tx(ser_tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_meta, m_las, m_lad, m_sel, m_stuck, m_chr;
    logic        m_fv, m_any;
    logic [2:0]  m_idx;
    int          m_timer;
    bit          m_pend, m_tx, m_busy;
    bit          txq[$];
    logic [14:0] m_frames[$];
    bit          obs[$];
    logic [7:0]  card, card_stuck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_meta = '0; m_las = '0; m_lad = '0; m_sel = '0; m_stuck = '0; m_chr = '0;
        m_fv = 1'b0; m_any = 1'b0; m_idx = '0; m_timer = 0;
        m_pend = 1'b0; m_tx = 1'b1; m_busy = 1'b0;
        txq.delete();
    endtask

    // One clock of the reference, using pre-edge values.
    task automatic model_step();
        logic [7:0]  las;
        logic [14:0] fr;
        bit          chg, last, start, fv_clr;
        las = m_las;
        chg = (m_las != m_lad);
        fv_clr = 1'b0;
        if (m_timer == 0) begin
            if (ack_req) begin
                if ((ack_mask & las) != 0) begin
                    m_sel = ack_mask & las;
                    m_timer = RP + ST + 3;
                end else if (las == 0) fv_clr = 1'b1;
            end
        end else begin
            m_timer--;
            if (m_timer == 0) begin
                m_stuck = m_stuck | (m_sel & las);
                if (las == 0) fv_clr = 1'b1;
            end
        end
        m_chr = (m_timer > ST + 3) ? m_sel : 8'h00;
        if (!m_fv && las != 0) begin
            m_fv = 1'b1;
            m_idx = lowest(las);
        end else if (fv_clr) m_fv = 1'b0;
        m_any = |las;
        last = m_busy && (txq.size() == 0);
        start = 1'b0;
        if (!m_busy && chg) start = 1'b1;
        else if (last && (m_pend || chg)) begin start = 1'b1; m_pend = 1'b0; end
        else if (m_busy && chg) m_pend = 1'b1;
        if (start) begin
            fr = {1'b1, ^{las, m_idx, m_fv}, m_fv, m_idx, las, 1'b0};
            m_frames.push_back(fr);
            for (int b = 0; b < FW; b++)
                for (int k = 0; k < BD; k++) txq.push_back(fr[b]);
        end
        if (txq.size() > 0) begin m_tx = txq.pop_front(); m_busy = 1'b1; end
        else begin m_tx = 1'b1; m_busy = 1'b0; end
        m_lad = m_las; m_las = m_meta; m_meta = la_in;
    endtask

    task automatic compare_all();
        chk("ser_tx", 32'(ser_tx), 32'(m_tx));
        chk("tx_busy", 32'(tx_busy), 32'(m_busy));
        chk("ch_reset", 32'(ch_reset), 32'(m_chr));
        chk("any_alarm", 32'(any_alarm), 32'(m_any));
        chk("first_valid", 32'(first_valid), 32'(m_fv));
        chk("first_idx", 32'(first_idx), 32'(m_idx));
        chk("stuck", 32'(stuck), 32'(m_stuck));
        if (tx_busy === 1'b1) obs.push_back(ser_tx);
    endtask

    task automatic set_card(input logic [7:0] v);
        card = v;
        la_in = v;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
        card = card & ~(m_chr & ~card_stuck);
        la_in = card;
    endtask

    task automatic tick_count(input int n, input logic [7:0] v, inout int pc);
        for (int i = 0; i < n; i++) begin
            tick();
            if (ch_reset === v) pc++;
        end
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while (!(!m_busy && txq.size() == 0 && m_timer == 0 && !m_pend && m_meta == la_in &&
                 m_las == m_meta && m_lad == m_las) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL %s timeout actual=busy required=quiet", name);
        end
    endtask

    task automatic decode(input int base, output logic [14:0] w, output int werr);
        w = '0; werr = 0;
        for (int b = 0; b < FW; b++) begin
            w[b] = obs[base + b*BD];
            for (int k = 1; k < BD; k++) if (obs[base + b*BD + k] != obs[base + b*BD]) werr++;
        end
    endtask

    initial begin
        logic [14:0] w;
        int werr, pc, f0, n;
        reset = 1'b1; ack_req = 1'b0; ack_mask = '0; card_stuck = '0;
        set_card(8'h00);
        model_reset();
        repeat (3) tick();
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        repeat (100) tick();
        chk("idle_ser_tx", 32'(ser_tx), 32'd1);
        chk("idle_outputs", {8'(ch_reset), 8'(stuck), 7'(first_idx), any_alarm, first_valid, tx_busy},
            32'd0);

        // First alarm, then two changes inside the frame collapse into one follow-up frame.
        obs.delete(); f0 = m_frames.size();
        set_card(8'h24);
        repeat (3) tick();
        chk("fo_idx", 32'(first_idx), 32'd2);
        chk("fo_valid", 32'(first_valid), 32'd1);
        repeat (20) tick();
        set_card(8'h25);
        repeat (22) tick();
        set_card(8'h2D);
        wait_quiet("t3");
        chk("t3_frames", 32'(m_frames.size() - f0), 32'd2);
        chk("t2_model_frame", 32'(m_frames[f0]), 32'h5448);
        chk("t3_obs_len", 32'(obs.size()), 32'd120);
        decode(0, w, werr);
        chk("t2_frame", 32'(w), 32'h5448);
        chk("t2_width", 32'(werr), 32'd0);
        decode(60, w, werr);
        chk("t3_frame", 32'(w), 32'h545A);
        chk("t3_width", 32'(werr), 32'd0);
        chk("t3_idx", 32'(first_idx), 32'd2);

        // Acknowledge clears bit 2; bit 0 remains.
        set_card(8'h05);
        wait_quiet("t4_pre");
        obs.delete();
        ack_mask = 8'h04; ack_req = 1'b1; pc = 0;
        tick_count(1, 8'h04, pc);
        ack_req = 1'b0;
        tick_count(40, 8'h04, pc);
        wait_quiet("t4");
        chk("t4_pulse_len", 32'(pc), 32'd16);
        chk("t4_stuck", 32'(stuck), 32'd0);
        chk("t4_fv", 32'(first_valid), 32'd1);
        chk("t4_obs_len", 32'(obs.size()), 32'd60);
        decode(0, w, werr);
        chk("t4_frame", 32'(w), 32'h7402);

        // Bit 0 refuses to clear; a second ack during the pulse is dropped.
        card_stuck = 8'h01;
        ack_mask = 8'hFF; ack_req = 1'b1; pc = 0;
        tick_count(1, 8'h01, pc);
        ack_req = 1'b0;
        tick_count(5, 8'h01, pc);
        ack_req = 1'b1;
        tick_count(1, 8'h01, pc);
        ack_req = 1'b0;
        tick_count(30, 8'h01, pc);
        chk("t5_pulse_len", 32'(pc), 32'd16);
        chk("t5_stuck", 32'(stuck), 32'h01);
        chk("t5_fv", 32'(first_valid), 32'd1);
        card_stuck = 8'h00;
        ack_req = 1'b1;
        tick();
        ack_req = 1'b0;
        wait_quiet("t5");
        chk("t5_fv_clear", 32'(first_valid), 32'd0);
        chk("t5_stuck_sticky", 32'(stuck), 32'h01);
        chk("t5_any", 32'(any_alarm), 32'd0);

        // Reset during frame bit 7 and during a reset pulse.
        set_card(8'h81);
        n = 0;
        while (!m_busy && n < 20) begin tick(); n++; end
        chk("t6_started", 32'(m_busy), 32'd1);
        repeat (20) tick();
        ack_mask = 8'h80; ack_req = 1'b1;
        tick();
        ack_req = 1'b0;
        repeat (4) tick();
        chk("t6_pre_busy", 32'(tx_busy), 32'd1);
        chk("t6_pre_chr", 32'(ch_reset), 32'h80);
        reset = 1'b1;
        #1;
        chk("t6_rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("t6_rst_chr", 32'(ch_reset), 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        obs.delete();
        wait_quiet("t6");
        chk("t6_obs_len", 32'(obs.size()), 32'd60);
        decode(0, w, werr);
        chk("t6_frame", 32'(w), 32'h5002);

        // Random alarms, acks, stuck channels and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) set_card(card | (8'h01 << $urandom_range(0, 7)));
            if ($urandom_range(0, 199) == 0)
                card_stuck = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            ack_req = ($urandom_range(0, 49) == 0);
            ack_mask = 8'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1; ack_req = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        ack_req = 1'b0;
        wait_quiet("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
